// File: rtl/chess_pkg.sv
// ----------------------------------------------------------------------------
// chess_pkg
//   Shared encodings for the chess-clock turn controller:
//     - FSM state codes (plain logic constants so legacy code can compare
//       against them directly)
//     - WINNER output codes
//     - move counter width
// ----------------------------------------------------------------------------
package chess_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_RUN_P1 = 3'd1;
    localparam state_t ST_RUN_P2 = 3'd2;
    localparam state_t ST_PAUSED = 3'd3;
    localparam state_t ST_OVER   = 3'd4;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam int unsigned CNT_W = 10;

endpackage

// File: rtl/edge_capture.sv
// ----------------------------------------------------------------------------
// edge_capture
//   Rising-edge detector on a debounced, CLK-synchronous button level,
//   followed by a sticky pending bit.
//   Ports:
//     CLK      in   system clock
//     CLR      in   asynchronous active-high reset (clears prev and pending)
//     btn      in   button level
//     consume  in   clears the pending bit on this edge
//     pending  out  a rising edge has been seen and not yet consumed
// ----------------------------------------------------------------------------
module edge_capture (
    input  logic CLK,
    input  logic CLR,
    input  logic btn,
    input  logic consume,
    output logic pending
);

    logic prev;
    logic rise;

    assign rise = btn & ~prev;

    // A rise on the consuming edge wins over the clear, so a press that
    // coincides with consumption is kept for the next CE cycle.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            prev    <= 1'b0;
            pending <= 1'b0;
        end else begin
            prev    <= btn;
            pending <= rise | (pending & ~consume);
        end
    end

endmodule

// File: rtl/turn_controller.sv
// ----------------------------------------------------------------------------
// turn_controller
//   Chess-clock game/turn sequencer. Captures button presses into pending
//   bits, then on each CE=1 edge advances the game FSM
//   (IDLE, RUN_P1, RUN_P2, PAUSED, OVER). All outputs are registered.
//   Parameters:
//     INC_EN     1 = pulse INC_Px to the player who just completed a move
//     MAX_MOVES  saturation value of MOVE_CNT
//   Ports:
//     CLK, CLR             clock, asynchronous active-high reset
//     CE                   processing strobe
//     BTN_P1, BTN_P2       player move buttons
//     BTN_START, BTN_NEW   start/pause/resume, new game
//     ZERO_P1, ZERO_P2     player time-expired flags
//     SELECT               active player (0 = P1, 1 = P2)
//     STOP                 clocks halted
//     END                  game finished
//     WINNER               00 none, 01 P1, 10 P2
//     MOVE_CNT             completed full moves
//     INC_P1, INC_P2       one-cycle increment pulses
//     LOAD                 one-cycle reload pulse for both player counters
// ----------------------------------------------------------------------------
module turn_controller
    import chess_pkg::*;
#(
    parameter int INC_EN    = 1,
    parameter int MAX_MOVES = 999
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CE,
    input  logic             BTN_P1,
    input  logic             BTN_P2,
    input  logic             BTN_START,
    input  logic             BTN_NEW,
    input  logic             ZERO_P1,
    input  logic             ZERO_P2,
    output logic             SELECT,
    output logic             STOP,
    output logic             END,
    output logic [1:0]       WINNER,
    output logic [CNT_W-1:0] MOVE_CNT,
    output logic             INC_P1,
    output logic             INC_P2,
    output logic             LOAD
);

    localparam logic             INC_ON  = (INC_EN != 0);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOVES);

    state_t state;
    logic   pend_p1;
    logic   pend_p2;
    logic   pend_start;
    logic   pend_new;

    // Every pending bit is consumed on each CE cycle, acted on or not.
    edge_capture u_cap_p1 (
        .CLK     (CLK),
        .CLR     (CLR),
        .btn     (BTN_P1),
        .consume (CE),
        .pending (pend_p1)
    );

    edge_capture u_cap_p2 (
        .CLK     (CLK),
        .CLR     (CLR),
        .btn     (BTN_P2),
        .consume (CE),
        .pending (pend_p2)
    );

    edge_capture u_cap_start (
        .CLK     (CLK),
        .CLR     (CLR),
        .btn     (BTN_START),
        .consume (CE),
        .pending (pend_start)
    );

    edge_capture u_cap_new (
        .CLK     (CLK),
        .CLR     (CLR),
        .btn     (BTN_NEW),
        .consume (CE),
        .pending (pend_new)
    );

    // Within a CE cycle: active ZERO flag, then NEW, then the active
    // player's move button, then START. Buttons that have no meaning in the
    // current state are treated as absent.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= ST_IDLE;
            SELECT   <= 1'b0;
            STOP     <= 1'b1;
            END      <= 1'b0;
            WINNER   <= WIN_NONE;
            MOVE_CNT <= '0;
            INC_P1   <= 1'b0;
            INC_P2   <= 1'b0;
            LOAD     <= 1'b0;
        end else begin
            // Pulses last one CLK cycle regardless of CE.
            INC_P1 <= 1'b0;
            INC_P2 <= 1'b0;
            LOAD   <= 1'b0;
            if (CE) begin
                case (state)
                    ST_IDLE: begin
                        if (pend_start) begin
                            state <= ST_RUN_P1;
                            STOP  <= 1'b0;
                        end
                    end
                    ST_RUN_P1: begin
                        if (ZERO_P1) begin
                            state  <= ST_OVER;
                            STOP   <= 1'b1;
                            END    <= 1'b1;
                            WINNER <= WIN_P2;
                        end else if (pend_p1) begin
                            state  <= ST_RUN_P2;
                            SELECT <= 1'b1;
                            INC_P1 <= INC_ON;
                        end else if (pend_start) begin
                            state <= ST_PAUSED;
                            STOP  <= 1'b1;
                        end
                    end
                    ST_RUN_P2: begin
                        if (ZERO_P2) begin
                            state  <= ST_OVER;
                            STOP   <= 1'b1;
                            END    <= 1'b1;
                            WINNER <= WIN_P1;
                        end else if (pend_p2) begin
                            state  <= ST_RUN_P1;
                            SELECT <= 1'b0;
                            INC_P2 <= INC_ON;
                            if (MOVE_CNT < MAX_CNT) begin
                                MOVE_CNT <= MOVE_CNT + 1'b1;
                            end
                        end else if (pend_start) begin
                            state <= ST_PAUSED;
                            STOP  <= 1'b1;
                        end
                    end
                    ST_PAUSED: begin
                        if (pend_new) begin
                            state    <= ST_IDLE;
                            SELECT   <= 1'b0;
                            STOP     <= 1'b1;
                            END      <= 1'b0;
                            WINNER   <= WIN_NONE;
                            MOVE_CNT <= '0;
                            LOAD     <= 1'b1;
                        end else if (pend_start) begin
                            // SELECT was held through the pause, so it
                            // names the player whose clock resumes.
                            state <= SELECT ? ST_RUN_P2 : ST_RUN_P1;
                            STOP  <= 1'b0;
                        end
                    end
                    ST_OVER: begin
                        if (pend_new) begin
                            state    <= ST_IDLE;
                            SELECT   <= 1'b0;
                            STOP     <= 1'b1;
                            END      <= 1'b0;
                            WINNER   <= WIN_NONE;
                            MOVE_CNT <= '0;
                            LOAD     <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        SELECT <= 1'b0;
                        STOP   <= 1'b1;
                        END    <= 1'b0;
                        WINNER <= WIN_NONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_turn_controller.sv
// ----------------------------------------------------------------------------
// tb_turn_controller
//   Scoreboard bench for turn_controller. Two instances share all inputs:
//   one with default parameters, one with MAX_MOVES=2. Stimulus pushes the
//   hand-computed expected outputs, tagged with the cycle at which they must
//   be visible; a separate monitor pops and compares on each falling edge.
// ----------------------------------------------------------------------------
module tb_turn_controller;

    typedef struct packed {
        logic       sel;
        logic       stop;
        logic       endf;
        logic [1:0] win;
        logic [9:0] cnt;
        logic       inc1;
        logic       inc2;
        logic       load;
    } out_t;

    typedef struct {
        int         tag;
        out_t       exp;
        logic [9:0] cnt2;
    } item_t;

    localparam logic [3:0] B_P1    = 4'b0001;
    localparam logic [3:0] B_P2    = 4'b0010;
    localparam logic [3:0] B_START = 4'b0100;
    localparam logic [3:0] B_NEW   = 4'b1000;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       CE  = 1'b1;
    logic [3:0] btns = 4'b0000;
    logic       ZERO_P1 = 1'b0;
    logic       ZERO_P2 = 1'b0;

    logic       sel_a, stop_a, end_a, inc1_a, inc2_a, load_a;
    logic [1:0] win_a;
    logic [9:0] cnt_a;
    logic       sel_b, stop_b, end_b, inc1_b, inc2_b, load_b;
    logic [1:0] win_b;
    logic [9:0] cnt_b;

    int    cyc   = 0;
    int    tests = 0;
    int    fails = 0;
    item_t q[$];
    item_t it;
    out_t  e;
    logic [9:0] cnt2;
    out_t  act_a, act_b, exp_b;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    turn_controller dut (
        .CLK(CLK), .CLR(CLR), .CE(CE),
        .BTN_P1(btns[0]), .BTN_P2(btns[1]), .BTN_START(btns[2]), .BTN_NEW(btns[3]),
        .ZERO_P1(ZERO_P1), .ZERO_P2(ZERO_P2),
        .SELECT(sel_a), .STOP(stop_a), .END(end_a), .WINNER(win_a),
        .MOVE_CNT(cnt_a), .INC_P1(inc1_a), .INC_P2(inc2_a), .LOAD(load_a)
    );

    turn_controller #(.INC_EN(1), .MAX_MOVES(2)) dut_max2 (
        .CLK(CLK), .CLR(CLR), .CE(CE),
        .BTN_P1(btns[0]), .BTN_P2(btns[1]), .BTN_START(btns[2]), .BTN_NEW(btns[3]),
        .ZERO_P1(ZERO_P1), .ZERO_P2(ZERO_P2),
        .SELECT(sel_b), .STOP(stop_b), .END(end_b), .WINNER(win_b),
        .MOVE_CNT(cnt_b), .INC_P1(inc1_b), .INC_P2(inc2_b), .LOAD(load_b)
    );

    // Monitor: compare every expectation whose cycle tag has come due.
    always @(negedge CLK) begin
        act_a = {sel_a, stop_a, end_a, win_a, cnt_a, inc1_a, inc2_a, load_a};
        act_b = {sel_b, stop_b, end_b, win_b, cnt_b, inc1_b, inc2_b, load_b};
        while (q.size() > 0 && q[0].tag <= cyc) begin
            it = q.pop_front();
            exp_b = it.exp;
            exp_b.cnt = it.cnt2;
            tests = tests + 1;
            if (it.tag != cyc || act_a !== it.exp) begin
                fails = fails + 1;
                $display("FAIL dut cyc=%0d tag=%0d got=%h exp=%h (sel,stop,end,win,cnt,inc1,inc2,load)",
                         cyc, it.tag, act_a, it.exp);
            end
            tests = tests + 1;
            if (it.tag != cyc || act_b !== exp_b) begin
                fails = fails + 1;
                $display("FAIL dut_max2 cyc=%0d tag=%0d got=%h exp=%h (sel,stop,end,win,cnt,inc1,inc2,load)",
                         cyc, it.tag, act_b, exp_b);
            end
        end
    end

    task automatic push(input int d);
        item_t t;
        t.tag  = cyc + d;
        t.exp  = e;
        t.cnt2 = cnt2;
        q.push_back(t);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // One-cycle press; returns on the following falling edge, one edge
    // before the FSM acts on it.
    task automatic press(input logic [3:0] m);
        btns = m;
        @(negedge CLK);
        btns = 4'b0000;
    endtask

    initial begin
        logic [9:0] c2_tab [3];
        c2_tab[0] = 10'd1;
        c2_tab[1] = 10'd2;
        c2_tab[2] = 10'd2;

        // Reset state
        e = '{sel: 1'b0, stop: 1'b1, endf: 1'b0, win: 2'b00, cnt: 10'd0,
              inc1: 1'b0, inc2: 1'b0, load: 1'b0};
        cnt2 = 10'd0;
        idle(1);
        push(1);
        idle(1);
        CLR = 1'b0;
        idle(2);

        // START -> RUN_P1
        press(B_START); e.stop = 1'b0; push(1); push(2); idle(2);
        // P1 move -> SELECT=1, single INC_P1 pulse, MOVE_CNT unchanged
        press(B_P1); e.sel = 1'b1; e.inc1 = 1'b1; push(1); e.inc1 = 1'b0; push(2); idle(2);

        // Three full moves; second instance saturates at 2
        for (int i = 0; i < 3; i++) begin
            if (i != 0) begin
                press(B_P1); e.sel = 1'b1; e.inc1 = 1'b1; push(1); e.inc1 = 1'b0; push(2); idle(2);
            end
            press(B_P2);
            e.sel = 1'b0; e.inc2 = 1'b1; e.cnt = 10'(i + 1); cnt2 = c2_tab[i];
            push(1); e.inc2 = 1'b0; push(2); idle(2);
        end

        // P1 held for 5 cycles with CE=0: nothing moves, then exactly one move
        CE = 1'b0; btns = B_P1; push(1);
        for (int k = 0; k < 4; k++) begin
            idle(1); push(1);
        end
        idle(1);
        btns = 4'b0000; CE = 1'b1;
        e.sel = 1'b1; e.inc1 = 1'b1; push(1);
        e.inc1 = 1'b0; push(2); push(4);
        idle(4);

        // Pause in RUN_P2; move buttons ignored; resume into RUN_P2
        press(B_START); e.stop = 1'b1; push(1); push(2); idle(2);
        press(B_P1); push(1); idle(2);
        press(B_P2); push(1); idle(2);
        press(B_START); e.stop = 1'b0; push(1); idle(2);
        press(B_P2); e.sel = 1'b0; e.inc2 = 1'b1; e.cnt = 10'd4; push(1);
        e.inc2 = 1'b0; push(2); idle(2);

        // Inactive player's ZERO flag ignored in RUN_P1
        ZERO_P2 = 1'b1; push(1); push(3); idle(3); ZERO_P2 = 1'b0;

        // ZERO_P1 beats a simultaneous P1 move: OVER, winner P2, no INC_P1
        press(B_P1); ZERO_P1 = 1'b1;
        e.stop = 1'b1; e.endf = 1'b1; e.win = 2'b10; push(1);
        idle(1); ZERO_P1 = 1'b0; push(1); idle(2);

        // OVER ignores START and moves
        press(B_START); push(1); idle(2);
        press(B_P1); push(1); idle(2);

        // NEW in OVER -> IDLE, LOAD pulse, counters cleared
        press(B_NEW);
        e = '{sel: 1'b0, stop: 1'b1, endf: 1'b0, win: 2'b00, cnt: 10'd0,
              inc1: 1'b0, inc2: 1'b0, load: 1'b1};
        cnt2 = 10'd0;
        push(1); e.load = 1'b0; push(2); idle(2);

        // NEW in IDLE ignored
        press(B_NEW); push(1); idle(2);

        // NEW beats START in PAUSED
        press(B_START); e.stop = 1'b0; push(1); idle(2);
        press(B_START); e.stop = 1'b1; push(1); idle(2);
        press(B_NEW | B_START); e.load = 1'b1; push(1); e.load = 1'b0; push(2); idle(2);

        // Mid-game CLR acts without CE
        press(B_START); e.stop = 1'b0; push(1); idle(2);
        press(B_P1); e.sel = 1'b1; e.inc1 = 1'b1; push(1); e.inc1 = 1'b0; push(2); idle(2);
        CE = 1'b0; CLR = 1'b1;
        e = '{sel: 1'b0, stop: 1'b1, endf: 1'b0, win: 2'b00, cnt: 10'd0,
              inc1: 1'b0, inc2: 1'b0, load: 1'b0};
        push(1); idle(2);
        CLR = 1'b0; CE = 1'b1;
        push(2); idle(3);

        // Every expectation must have been consumed
        tests = tests + 1;
        if (q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
